// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, parallel load, shifts and rotates, sequenced one position per clock.
// Optional macro SHIFT_PARITY_EN adds output par = ^Q.
module shift_reg_univ #(
    parameter int              WIDTH     = 8,
    parameter int              CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             busy,
    output logic             done,
`ifdef SHIFT_PARITY_EN
    output logic             par,
`endif
    output logic             dbg_state
);
    // Handshake: start is sampled only in IDLE; busy is high while shift edges remain;
    // done pulses for one cycle after the edge that completes an accepted operation.

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_r, q_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         op, op_nxt;
    logic               done_r, done_nxt;

    function automatic logic [WIDTH-1:0] shift_one(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                                   input logic sl, input logic sr);
        case (m)
            3'b010:  shift_one = {v[WIDTH-2:0], sr};
            3'b011:  shift_one = {sl, v[WIDTH-1:1]};
            3'b100:  shift_one = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b101:  shift_one = {v[0], v[WIDTH-1:1]};
            3'b110:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_one = v;
        endcase
    endfunction

    always_comb begin
        q_nxt     = q_r;
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op;
        done_nxt  = 1'b0;
        if (pre) begin
            // Preset aborts any sequence in flight without a done pulse.
            q_nxt     = {WIDTH{1'b1}};
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mode)
                            3'b000, 3'b111: done_nxt = 1'b1;
                            3'b001: begin
                                q_nxt    = D;
                                done_nxt = 1'b1;
                            end
                            default: begin
                                if (amt == '0) begin
                                    done_nxt = 1'b1;
                                end else begin
                                    op_nxt    = mode;
                                    cnt_nxt   = amt;
                                    state_nxt = SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    q_nxt   = shift_one(op, q_r, sin_l, sin_r);
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            q_r    <= RESET_VAL;
            cnt    <= '0;
            op     <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            cnt    <= cnt_nxt;
            op     <= op_nxt;
            done_r <= done_nxt;
        end
    end

    assign Q         = q_r;
    assign Qn        = ~q_r;
    assign busy      = (state == SHIFT);
    assign done      = done_r;
    assign dbg_state = state;
`ifdef SHIFT_PARITY_EN
    assign par       = ^q_r;
`endif

endmodule
